// File: rtl/sym_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sym_pkg
// Purpose : Shared types and helpers for the symmetric frame detector:
//           FSM state encoding, bit-reversal and width derivation.
// Rev     : 1.0  initial release
// ============================================================================
package sym_pkg;

  // Detector phases: collect words, compare mirrored pairs, hold the result.
  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Widest word the bit-reversal helper handles.
  localparam int MAX_W = 64;

  // Address width for a DEPTH-entry buffer.
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Width able to hold a frame length of 0..DEPTH.
  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width able to hold a mismatch count of 0..DEPTH/2.
  function automatic int mis_width(input int depth);
    return $clog2(depth / 2 + 1);
  endfunction

  // Reverse the low w bits of v; bits above w come back as zero.
  function automatic logic [MAX_W-1:0] bitreverse(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] r;
    logic [5:0]       idx;
    r   = '0;
    idx = '0;
    for (int k = 0; k < MAX_W; k++) begin
      if (k < w) begin
        idx  = 6'(w - 1 - k);
        r[k] = v[idx];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sym_buf.sv
`default_nettype none
// ============================================================================
// Module  : sym_buf
// Purpose : DEPTH x WIDTH frame buffer, one synchronous write port and two
//           combinational read ports. Contents are not reset.
// Rev     : 1.0  initial release
// ============================================================================
module sym_buf
  import sym_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [WIDTH-1:0]  o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [WIDTH-1:0]  o_rdata_b
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store accepted words; storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/sym_frame_detector.sv
`default_nettype none
// ============================================================================
// Module  : sym_frame_detector
// Purpose : Buffers a frame of up to DEPTH words, then checks one mirrored
//           pair per cycle for word or bit-mirror palindrome symmetry and
//           reports the mismatch count, length and truncation flag.
//           WIDTH must not exceed sym_pkg::MAX_W.
// Rev     : 1.0  initial release
// ============================================================================
module sym_frame_detector
  import sym_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_last,
  input  logic                         mode,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sym,
  output logic [mis_width(DEPTH)-1:0]  out_mismatch,
  output logic [len_width(DEPTH)-1:0]  out_len,
  output logic                         out_overflow
);

  localparam int ADDR_W = addr_width(DEPTH);
  localparam int LEN_W  = len_width(DEPTH);
  localparam int MIS_W  = mis_width(DEPTH);
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [LEN_W-1:0]  r_len;
  logic              r_mode;
  logic              r_ovf;
  logic [MIS_W-1:0]  r_mis;

  logic              w_accept;
  logic              w_full;
  logic              w_close;
  logic              w_last_pair;
  logic              w_pair_match;
  logic [LEN_W-1:0]  w_n;
  logic [LEN_W-1:0]  w_half;
  logic [ADDR_W-1:0] w_raddr_b;
  logic [WIDTH-1:0]  w_rd_a;
  logic [WIDTH-1:0]  w_rd_b;
  logic [WIDTH-1:0]  w_rd_b_cmp;

  assign in_ready  = (r_state == ST_LOAD);
  assign w_accept  = in_valid && in_ready;
  // The word at the last buffer slot closes the frame whether or not it is marked last.
  assign w_full    = (r_wr_cnt == C_LAST_ADDR);
  assign w_close   = w_accept && (in_last || w_full);
  assign w_n       = LEN_W'(r_wr_cnt) + LEN_W'(1);

  // Pair i is (r_idx, N-1-r_idx); the final pair is i = N/2 - 1.
  assign w_half       = r_len >> 1;
  assign w_last_pair  = (LEN_W'(r_idx) == (w_half - LEN_W'(1)));
  assign w_raddr_b    = ADDR_W'(r_len - LEN_W'(1) - LEN_W'(r_idx));
  assign w_rd_b_cmp   = r_mode ? WIDTH'(bitreverse(MAX_W'(w_rd_b), WIDTH)) : w_rd_b;
  assign w_pair_match = (w_rd_a == w_rd_b_cmp);

  sym_buf #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk       (clk),
    .i_we      (w_accept),
    .i_waddr   (r_wr_cnt),
    .i_wdata   (in_data),
    .i_raddr_a (r_idx),
    .o_rdata_a (w_rd_a),
    .i_raddr_b (w_raddr_b),
    .o_rdata_b (w_rd_b)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection; frames shorter than two words have nothing to compare.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_close) begin
          w_next = (w_n >= LEN_W'(2)) ? ST_CHECK : ST_REPORT;
        end
      end
      ST_CHECK: begin
        if (w_last_pair) begin
          w_next = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (out_valid && out_ready) begin
          w_next = ST_LOAD;
        end
      end
      default: begin
        w_next = ST_LOAD;
      end
    endcase
  end

  // Frame capture, pair counting and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt     <= '0;
      r_idx        <= '0;
      r_len        <= '0;
      r_mode       <= 1'b0;
      r_ovf        <= 1'b0;
      r_mis        <= '0;
      out_valid    <= 1'b0;
      out_sym      <= 1'b0;
      out_mismatch <= '0;
      out_len      <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_accept) begin
            // Mode is taken from the first word only.
            if (r_wr_cnt == '0) begin
              r_mode <= mode;
            end
            if (w_close) begin
              r_len    <= w_n;
              r_ovf    <= !in_last;
              r_wr_cnt <= '0;
              r_idx    <= '0;
              r_mis    <= '0;
            end else begin
              r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (!w_pair_match) begin
            r_mis <= r_mis + MIS_W'(1);
          end
          r_idx <= r_idx + ADDR_W'(1);
        end
        ST_REPORT: begin
          // First REPORT cycle publishes the result; it then holds until consumed.
          if (!out_valid) begin
            out_valid    <= 1'b1;
            out_sym      <= (r_mis == '0);
            out_mismatch <= r_mis;
            out_len      <= r_len;
            out_overflow <= r_ovf;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            r_wr_cnt  <= '0;
          end
        end
        default: begin
          r_wr_cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sym_frame_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_sym_frame_detector
// Purpose : Self-checking bench: directed table of frames, overflow and reset
//           corner cases, and random frames against a reference model.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sym_frame_detector;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int MIS_W = $clog2(DEPTH / 2 + 1);
  localparam int LEN_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             mode;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_sym;
  logic [MIS_W-1:0] out_mismatch;
  logic [LEN_W-1:0] out_len;
  logic             out_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit prod_done = 1'b0;

  typedef struct packed {
    logic                        m;
    logic [4:0]                  n;
    logic [0:DEPTH-1][WIDTH-1:0] w;
    logic                        e_sym;
    logic [3:0]                  e_mis;
  } vec_t;

  typedef struct packed {
    logic             sym;
    logic [MIS_W-1:0] mis;
    logic [LEN_W-1:0] len;
    logic             ovf;
  } res_t;

  vec_t             vecs [8];
  logic [WIDTH-1:0] cur [$];
  logic             cur_m;
  res_t             expq [$];

  sym_frame_detector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .mode         (mode),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sym      (out_sym),
    .out_mismatch (out_mismatch),
    .out_len      (out_len),
    .out_overflow (out_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int b = 0; b < WIDTH; b++) r[b] = x[WIDTH-1-b];
    return r;
  endfunction

  // Reference: count mirrored pairs that differ under the frame's mode.
  function automatic res_t model_result(input logic [WIDTH-1:0] q[$], input logic m, input logic ovf);
    res_t r;
    int   n;
    int   mis;
    n   = q.size();
    mis = 0;
    for (int i = 0; i < n / 2; i++) begin
      if (q[i] != (m ? rev(q[n-1-i]) : q[n-1-i])) mis++;
    end
    r.sym = (mis == 0);
    r.mis = MIS_W'(mis);
    r.len = LEN_W'(n);
    r.ovf = ovf;
    return r;
  endfunction

  task automatic model_word(input logic [WIDTH-1:0] d, input logic l, input logic m);
    if (cur.size() == 0) cur_m = m;
    cur.push_back(d);
    if (l || cur.size() == DEPTH) begin
      expq.push_back(model_result(cur, cur_m, !l));
      cur = {};
    end
  endtask

  // Present one word and wait for it to be accepted; t is the accepting edge.
  task automatic push_word(input logic [WIDTH-1:0] d, input logic l, input logic m, output int t);
    int w;
    w = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 200) begin
      in_valid = 1'b0;
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    mode     = m;
    @(posedge clk);
    #1;
    t = cyc;
  endtask

  task automatic end_frame();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait for a result, optionally hold it unconsumed, then consume it.
  task automatic get_result(input int hold, output logic sym, output logic [MIS_W-1:0] mis,
                            output logic [LEN_W-1:0] len, output logic ovf, output int tv);
    int w;
    w = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("out_valid_wait", out_valid, 1);
    tv  = cyc;
    sym = out_sym;
    mis = out_mismatch;
    len = out_len;
    ovf = out_overflow;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_stable", {out_valid, in_ready, out_sym, out_mismatch, out_len, out_overflow},
            {1'b1, 1'b0, sym, mis, len, ovf});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_out_valid", out_valid, 0);
  endtask

  task automatic run_vec(input int i);
    int               t;
    int               tv;
    logic             sym;
    logic             ovf;
    logic [MIS_W-1:0] mis;
    logic [LEN_W-1:0] len;
    vec_t             v;
    v = vecs[i];
    for (int k = 0; k < int'(v.n); k++) begin
      // Later words carry the opposite mode; only the first one may count.
      push_word(v.w[k], k == int'(v.n) - 1, (k == 0) ? v.m : ~v.m, t);
    end
    end_frame();
    get_result(0, sym, mis, len, ovf, tv);
    check($sformatf("v%0d_sym", i), sym, v.e_sym);
    check($sformatf("v%0d_mis", i), mis, v.e_mis);
    check($sformatf("v%0d_len", i), len, v.n);
    check($sformatf("v%0d_ovf", i), ovf, 0);
    check($sformatf("v%0d_latency", i), tv - t, 1 + int'(v.n) / 2);
  endtask

  initial begin
    int               t;
    int               tv;
    int               bad;
    logic             sym;
    logic             ovf;
    logic [MIS_W-1:0] mis;
    logic [LEN_W-1:0] len;

    vecs[0] = '{m:1'b0, n:5'd4,  w:128'h12343412_00000000_00000000_00000000, e_sym:1'b1, e_mis:4'd0};
    vecs[1] = '{m:1'b0, n:5'd5,  w:128'h01020304_05000000_00000000_00000000, e_sym:1'b0, e_mis:4'd2};
    vecs[2] = '{m:1'b1, n:5'd2,  w:128'h01800000_00000000_00000000_00000000, e_sym:1'b1, e_mis:4'd0};
    vecs[3] = '{m:1'b0, n:5'd2,  w:128'h01800000_00000000_00000000_00000000, e_sym:1'b0, e_mis:4'd1};
    vecs[4] = '{m:1'b0, n:5'd1,  w:128'hA5000000_00000000_00000000_00000000, e_sym:1'b1, e_mis:4'd0};
    vecs[5] = '{m:1'b1, n:5'd4,  w:128'h0155AA80_00000000_00000000_00000000, e_sym:1'b1, e_mis:4'd0};
    vecs[6] = '{m:1'b0, n:5'd16, w:128'h00010203_04050607_08090A0B_0C0D0E0F, e_sym:1'b0, e_mis:4'd8};
    vecs[7] = '{m:1'b1, n:5'd3,  w:128'h12344800_00000000_00000000_00000000, e_sym:1'b1, e_mis:4'd0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; mode = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {out_sym, out_mismatch, out_len, out_overflow}, 0);

    // Directed table.
    for (int i = 0; i < 8; i++) run_vec(i);

    // 17 words with last only on the 17th: truncation, held result, no lost word.
    for (int k = 0; k < 16; k++) push_word(WIDTH'(k), 1'b0, 1'b0, t);
    end_frame();
    get_result(5, sym, mis, len, ovf, tv);
    check("ovf1_len", len, 16);
    check("ovf1_ovf", ovf, 1);
    check("ovf1_mis", mis, 8);
    check("ovf1_latency", tv - t, 9);
    push_word(8'h11, 1'b1, 1'b0, t);
    end_frame();
    get_result(0, sym, mis, len, ovf, tv);
    check("ovf2_len", len, 1);
    check("ovf2_ovf", ovf, 0);
    check("ovf2_sym", sym, 1);

    // Reset in the middle of checking a full frame.
    for (int k = 0; k < 16; k++) push_word(WIDTH'(k), k == 15, 1'b0, t);
    end_frame();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    check("midrst_no_result", bad, 0);
    run_vec(0);

    // Random frames with idle gaps, mid-frame mode noise and output stalls.
    cur = {};
    expq = {};
    fork
      begin : producer
        int               L;
        int               pt;
        logic             m;
        logic             mk;
        logic [WIDTH-1:0] wq [$];
        for (int f = 0; f < 40; f++) begin
          L = $urandom_range(1, 20);
          m = 1'($urandom_range(0, 1));
          wq = {};
          for (int k = 0; k < L; k++) wq.push_back(WIDTH'($urandom));
          if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < L / 2; k++) wq[L-1-k] = m ? rev(wq[k]) : wq[k];
          end
          if ($urandom_range(0, 3) == 0) wq[$urandom_range(0, L - 1)] ^= WIDTH'(1);
          for (int k = 0; k < L; k++) begin
            if ($urandom_range(0, 4) == 0) begin
              @(negedge clk);
              in_valid = 1'b0;
              repeat ($urandom_range(1, 3)) @(posedge clk);
            end
            mk = (k == 0) ? m : 1'($urandom_range(0, 1));
            push_word(wq[k], k == L - 1, mk, pt);
            model_word(wq[k], k == L - 1, mk);
          end
          end_frame();
        end
        prod_done = 1'b1;
      end
      begin : consumer
        int   guard;
        res_t e;
        guard = 0;
        while (!(prod_done && expq.size() == 0) && guard < 20000) begin
          @(negedge clk);
          guard++;
          if (out_valid === 1'b1 && $urandom_range(0, 2) != 0) begin
            if (expq.size() == 0) begin
              check("rnd_unexpected_result", 1, 0);
            end else begin
              e = expq.pop_front();
              check("rnd_sym", out_sym, e.sym);
              check("rnd_mis", out_mismatch, e.mis);
              check("rnd_len", out_len, e.len);
              check("rnd_ovf", out_overflow, e.ovf);
            end
            out_ready = 1'b1;
          end else begin
            out_ready = 1'b0;
          end
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("rnd_completed", guard < 20000, 1);
      end
    join
    check("rnd_leftover", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sym_frame_detector.md
SYM_FRAME_DETECTOR -- requirements
Module: sym_frame_detector

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, maximum frame length in words (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, synchronous reset, active-high.
REQ-005 SHALL have port in_valid, input, 1, input word present.
REQ-006 SHALL have port in_data, input, WIDTH, input word.
REQ-007 SHALL have port in_last, input, 1, marks the final word of a frame.
REQ-008 SHALL have port mode, input, 1: 0 = word palindrome, 1 = bit-mirror palindrome.
REQ-009 SHALL have port in_ready, output, 1, word accepted when in_valid and in_ready are both high.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, result consumed when out_valid and out_ready are both high.
REQ-012 SHALL have port out_sym, output, 1, frame is symmetric.
REQ-013 SHALL have port out_mismatch, output, clog2(DEPTH/2+1), number of mismatched pairs.
REQ-014 SHALL have port out_len, output, clog2(DEPTH+1), number of words in the frame.
REQ-015 SHALL have port out_overflow, output, 1, frame was truncated at DEPTH words.

Function
REQ-016 SHALL implement FSM states LOAD, CHECK and REPORT.
REQ-017 SHALL assert in_ready only in LOAD; in_ready is a combinational function of state only.
REQ-018 In LOAD, SHALL store each accepted word at index wr_cnt and increment wr_cnt.
REQ-019 SHALL latch mode on the first accepted word of a frame; mode changes mid-frame have no effect.
REQ-020 On acceptance with in_last=1, SHALL set N = wr_cnt+1 and leave LOAD.
REQ-021 On acceptance of word DEPTH with in_last=0, SHALL close the frame with N=DEPTH and overflow=1.
REQ-022 After an overflow close, subsequent words SHALL start a new frame and SHALL NOT be discarded.
REQ-023 From LOAD, if N>=2 SHALL go to CHECK, otherwise SHALL go to REPORT.
REQ-024 CHECK SHALL compare one pair (i, N-1-i) per cycle for i = 0 .. floor(N/2)-1, then SHALL go to REPORT.
REQ-025 In mode 0, a pair SHALL match if word[i] == word[N-1-i].
REQ-026 In mode 1, a pair SHALL match if word[i] == bitreverse(word[N-1-i]).
REQ-027 SHALL increment the mismatch counter by 1 per unmatched pair; the counter cannot saturate.
REQ-028 For odd N, the middle word SHALL NOT be compared and SHALL NOT contribute a mismatch.
REQ-029 Latency: with the last word accepted on edge t, out_valid SHALL rise on edge t+1+floor(N/2).
REQ-030 In REPORT, SHALL hold out_valid=1 with out_sym (= mismatch==0), out_mismatch, out_len and out_overflow stable until out_ready=1.
REQ-031 On the out_valid and out_ready handshake edge, SHALL return to LOAD with wr_cnt=0 and out_valid=0 on the next cycle.
REQ-032 SHALL carry no bubble beyond the FSM path: in_ready=1 in the cycle immediately after the result handshake.

Reset
REQ-033 On a clk edge with rst=1, SHALL set state=LOAD, wr_cnt=0, the mismatch counter=0, out_valid=0, out_sym=0, out_mismatch=0, out_len=0 and out_overflow=0.
REQ-034 Reset in any state, including mid-CHECK and mid-REPORT, SHALL abandon the frame; in_ready=1 from the first cycle after reset.
REQ-035 Buffer contents SHALL NOT be reset.

Structure
REQ-036 Shared package sym_pkg SHALL hold the FSM state enum, the bitreverse function and the width-derivation constants.
REQ-037 Sub-module sym_buf SHALL be a DEPTH x WIDTH register file with one write port and two combinational read ports.
REQ-038 The FSM, counters and comparison SHALL reside in sym_frame_detector.

Verification
REQ-039 Mode 0, frame {0x12,0x34,0x34,0x12}, out_ready=1 -> out_sym=1, mismatch=0, len=4, out_valid 3 edges after last.
REQ-040 Mode 0, frame {0x01,0x02,0x03,0x04,0x05} -> out_sym=0, mismatch=2, len=5, overflow=0.
REQ-041 Mode 1, frame {0x01,0x80} -> out_sym=1; mode 0 on the same frame -> out_sym=0, mismatch=1.
REQ-042 Single word 0xA5 with last -> out_sym=1, mismatch=0, len=1, out_valid on the next edge.
REQ-043 17 words, last only on word 17 -> frame 1: len=16, overflow=1; frame 2: len=1, overflow=0; with out_ready held low 5 cycles, outputs SHALL stay stable and in_ready=0.
REQ-044 rst pulsed during CHECK of a 16-word frame -> out_valid stays 0, in_ready=1 on the next cycle, and the next frame is reported correctly.
